// File: rtl/sp_rd_lvds_rx_if.sv
// Output word stream of the LVDS receiver: FIFO head word with a valid/ready handshake.
// The master side (receiver) drives the word, the slave side (consumer) drives ready.
interface sp_rd_lvds_rx_if #(
  parameter int DOUT_W = 32
);
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/sp_rd_lvds_rx.sv
// Serial-parallel LVDS readout receiver: packs lane samples into words and queues them in a FIFO.
// Optional end-of-frame trailer word is compiled in with macro SP_RD_LVDS_TRAILER_EN.
module sp_rd_lvds_rx #(
  parameter int               LANES      = 8,
  parameter logic [LANES-1:0] INV_MASK   = {LANES{1'b1}},
  parameter logic [1:0]       INV_CTRL   = 2'b00,
  parameter int               DOUT_W     = 32,
  parameter int               FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                enable,
  input  logic                clr_ovf,
  input  logic [LANES-1:0]    SP_DOUT_P,
  input  logic [LANES-1:0]    SP_DOUT_N,
  input  logic                SP_UPDATE_P,
  input  logic                SP_UPDATE_N,
  input  logic                SP_EOF_P,
  input  logic                SP_EOF_N,
  sp_rd_lvds_rx_if.master     stream,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         frame_cnt
);

  localparam int SAMPLES = DOUT_W / LANES;
  localparam int CNT_W   = $clog2(SAMPLES + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  if (LANES < 1 || LANES > 16) begin : g_badLanes
    $error("sp_rd_lvds_rx: LANES must be within 1..16");
  end
  if (DOUT_W % LANES != 0) begin : g_badWidth
    $error("sp_rd_lvds_rx: DOUT_W must be a multiple of LANES");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
    $error("sp_rd_lvds_rx: FIFO_DEPTH must be a power of two >= 4");
  end

`ifdef SP_RD_LVDS_TRAILER_EN
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, TRAILER} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
`endif

  // Differential receivers are modelled as P AND NOT N, followed by the polarity fix-up.
  logic [LANES-1:0] w_lanes;
  logic             w_upd;
  logic             w_eof;
  assign w_lanes = (SP_DOUT_P & ~SP_DOUT_N) ^ INV_MASK;
  assign w_upd   = (SP_UPDATE_P & ~SP_UPDATE_N) ^ INV_CTRL[0];
  assign w_eof   = (SP_EOF_P & ~SP_EOF_N) ^ INV_CTRL[1];

  logic [LANES-1:0]  r_lanes;
  logic              r_upd;
  logic              r_eof;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DOUT_W-1:0] r_pack;
  logic              r_push;
  logic [DOUT_W-1:0] r_pushData;
  logic              r_wrEn;
  logic [DOUT_W-1:0] r_wrData;
  logic [15:0]       r_frameCnt;
  logic              r_overflow;
`ifdef SP_RD_LVDS_TRAILER_EN
  logic [15:0]       r_wordCnt;
  logic [7:0]        r_trlFrame;
`endif

  logic [DOUT_W-1:0] w_packNext;
  logic [CNT_W-1:0]  w_cntNext;
  logic              w_wordFull;

  always_comb begin
    w_packNext = r_pack;
    for (int s = 0; s < SAMPLES; s++) begin
      if (r_cnt == CNT_W'(s)) w_packNext[s*LANES +: LANES] = r_lanes;
    end
  end

  assign w_cntNext  = r_cnt + CNT_W'(1);
  assign w_wordFull = (w_cntNext == CNT_W'(SAMPLES));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lanes <= '0;
      r_upd   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_lanes <= w_lanes;
      r_upd   <= w_upd;
      r_eof   <= w_eof;
    end
  end

  // A word completed in RUN and a partial word in FLUSH both leave through r_push/r_pushData.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pack     <= '0;
      r_push     <= 1'b0;
      r_pushData <= '0;
      r_frameCnt <= '0;
`ifdef SP_RD_LVDS_TRAILER_EN
      r_wordCnt  <= '0;
      r_trlFrame <= '0;
`endif
    end else begin
      r_push <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) r_state <= RUN;
        end
        RUN: begin
          if (r_upd) begin
            if (w_wordFull) begin
              r_push     <= 1'b1;
              r_pushData <= w_packNext;
              r_pack     <= '0;
              r_cnt      <= '0;
`ifdef SP_RD_LVDS_TRAILER_EN
              r_wordCnt  <= r_wordCnt + 16'd1;
`endif
            end else begin
              r_pack <= w_packNext;
              r_cnt  <= w_cntNext;
            end
          end
          if (r_eof) r_state <= FLUSH;
        end
        FLUSH: begin
          if (r_cnt != '0) begin
            r_push     <= 1'b1;
            r_pushData <= r_pack;
            r_pack     <= '0;
            r_cnt      <= '0;
`ifdef SP_RD_LVDS_TRAILER_EN
            r_wordCnt  <= r_wordCnt + 16'd1;
`endif
          end
          r_frameCnt <= r_frameCnt + 16'd1;
`ifdef SP_RD_LVDS_TRAILER_EN
          r_trlFrame <= r_frameCnt[7:0];
          r_state    <= TRAILER;
`else
          r_state    <= enable ? RUN : IDLE;
`endif
        end
`ifdef SP_RD_LVDS_TRAILER_EN
        TRAILER: begin
          r_push     <= 1'b1;
          r_pushData <= DOUT_W'({8'hEF, r_trlFrame, r_wordCnt});
          r_wordCnt  <= '0;
          r_state    <= enable ? RUN : IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // One retiming stage ahead of the FIFO write port sets the pin-to-dout latency.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wrEn   <= 1'b0;
      r_wrData <= '0;
    end else begin
      r_wrEn   <= r_push;
      r_wrData <= r_pushData;
    end
  end

  logic [DOUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              w_pop;
  logic              w_full;
  logic              w_wrOk;
  logic              w_drop;

  assign w_pop  = (r_count != '0) && stream.dout_ready;
  assign w_full = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_wrOk = r_wrEn && (!w_full || w_pop);
  assign w_drop = r_wrEn && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wrOk) r_mem[r_wrPtr] <= r_wrData;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wrOk) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_wrOk && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
      else if (!w_wrOk && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign stream.dout       = (r_count != '0) ? r_mem[r_rdPtr] : '0;
  assign stream.dout_valid = (r_count != '0);
  assign busy              = (r_state != IDLE);
  assign overflow          = r_overflow;
  assign frame_cnt         = r_frameCnt;

endmodule

// File: tb/tb_sp_rd_lvds_rx.sv
// Directed bench for sp_rd_lvds_rx: two instances differing only in lane inversion mask.
// Trailer expectations follow SP_RD_LVDS_TRAILER_EN when the bench is built with it.
module tb_sp_rd_lvds_rx;

  logic       clk = 1'b0;
  logic       nrst;
  logic       enable;
  logic       clrOvf;
  logic [7:0] dinP;
  logic [7:0] dinN;
  logic       updP;
  logic       updN;
  logic       eofP;
  logic       eofN;
  logic       ready;
  logic [15:0] frameCnt0;
  logic [15:0] frameCnt1;
  logic       busy0;
  logic       busy1;
  logic       ovf0;
  logic       ovf1;

  int checkCount = 0;
  int failCount  = 0;

  sp_rd_lvds_rx_if #(.DOUT_W(32)) if0 ();
  sp_rd_lvds_rx_if #(.DOUT_W(32)) if1 ();
  assign if0.dout_ready = ready;
  assign if1.dout_ready = ready;

  always #5 clk = ~clk;

  sp_rd_lvds_rx #(.INV_MASK(8'h00)) dut0 (
    .clk(clk), .nrst(nrst), .enable(enable), .clr_ovf(clrOvf),
    .SP_DOUT_P(dinP), .SP_DOUT_N(dinN),
    .SP_UPDATE_P(updP), .SP_UPDATE_N(updN),
    .SP_EOF_P(eofP), .SP_EOF_N(eofN),
    .stream(if0), .busy(busy0), .overflow(ovf0), .frame_cnt(frameCnt0)
  );

  sp_rd_lvds_rx #(.INV_MASK(8'h01)) dut1 (
    .clk(clk), .nrst(nrst), .enable(enable), .clr_ovf(clrOvf),
    .SP_DOUT_P(dinP), .SP_DOUT_N(dinN),
    .SP_UPDATE_P(updP), .SP_UPDATE_N(updN),
    .SP_EOF_P(eofP), .SP_EOF_N(eofN),
    .stream(if1), .busy(busy1), .overflow(ovf1), .frame_cnt(frameCnt1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of pin values, returning at the following falling edge.
  task automatic applyStimulus(input logic [7:0] lanes, input logic upd, input logic eof);
    dinP = lanes;
    dinN = ~lanes;
    updP = upd;
    updN = ~upd;
    eofP = eof;
    eofN = ~eof;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  task automatic popWord();
    ready = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] expWord;
    int          popped;

    nrst   = 1'b0;
    enable = 1'b0;
    clrOvf = 1'b0;
    ready  = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    idleCycles(1);

    checkOutput("rstDout",     if0.dout, 32'h0);
    checkOutput("rstValid",    {31'b0, if0.dout_valid}, 32'h0);
    checkOutput("rstBusy",     {31'b0, busy0}, 32'h0);
    checkOutput("rstOverflow", {31'b0, ovf0}, 32'h0);
    checkOutput("rstFrameCnt", {16'b0, frameCnt0}, 32'h0);

    nrst   = 1'b1;
    enable = 1'b1;
    idleCycles(1);
    checkOutput("busyRun", {31'b0, busy0}, 32'h1);

    // Basic packing and exact pin-to-dout latency.
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("latencyEarly", {31'b0, if0.dout_valid}, 32'h0);
    idleCycles(1);
    checkOutput("latencyValid", {31'b0, if0.dout_valid}, 32'h1);
    checkOutput("packWord",     if0.dout, 32'h44332211);
    checkOutput("packWordInv",  if1.dout, 32'h45322310);
    popWord();
    checkOutput("popEmpty", {31'b0, if0.dout_valid}, 32'h0);

    // Lane 0 inversion.
    for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("invNone", if0.dout, 32'hFFFFFFFF);
    checkOutput("invLane0", if1.dout, 32'hFEFEFEFE);
    popWord();

    // Frame with EOF on the sixth sample: full word then padded partial word.
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0);
    applyStimulus(8'h66, 1'b1, 1'b1);
    idleCycles(8);
    checkOutput("eofFrameCnt", {16'b0, frameCnt0}, 32'h1);
    checkOutput("eofWord0", if0.dout, 32'h44332211);
    popWord();
    checkOutput("eofWord1", if0.dout, 32'h00006655);
    popWord();
`ifdef SP_RD_LVDS_TRAILER_EN
    checkOutput("eofTrailer", if0.dout, 32'hEF000002);
    popWord();
`endif
    checkOutput("eofDrained", {31'b0, if0.dout_valid}, 32'h0);
    checkOutput("eofBusy", {31'b0, busy0}, 32'h1);

    // Enable drops mid-frame: capture runs to EOF, then back to IDLE.
    applyStimulus(8'h01, 1'b1, 1'b0);
    enable = 1'b0;
    applyStimulus(8'h02, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b1);
    idleCycles(8);
    checkOutput("stopBusy", {31'b0, busy0}, 32'h0);
    checkOutput("stopFrameCnt", {16'b0, frameCnt0}, 32'h2);
    checkOutput("stopPadded", if0.dout, 32'h00030201);
    popWord();
`ifdef SP_RD_LVDS_TRAILER_EN
    checkOutput("stopTrailer", if0.dout, 32'hEF010001);
    popWord();
`endif
    checkOutput("stopDrained", {31'b0, if0.dout_valid}, 32'h0);
    applyStimulus(8'h77, 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("idleIgnoresUpd", {31'b0, if0.dout_valid}, 32'h0);

    // Overflow: 17 words into a 16-deep FIFO with the consumer stalled.
    enable = 1'b1;
    idleCycles(1);
    for (int i = 0; i < 68; i++) applyStimulus(8'(i), 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("ovfSet", {31'b0, ovf0}, 32'h1);
    popped = 0;
    for (int j = 0; j < 20 && if0.dout_valid; j++) begin
      for (int s = 0; s < 4; s++) expWord[s*8 +: 8] = 8'(4 * j + s);
      checkOutput($sformatf("ovfWord%0d", j), if0.dout, expWord);
      popWord();
      popped++;
    end
    checkOutput("ovfDepth", 32'(popped), 32'd16);
    checkOutput("ovfSticky", {31'b0, ovf0}, 32'h1);
    clrOvf = 1'b1;
    idleCycles(1);
    clrOvf = 1'b0;
    checkOutput("ovfClear", {31'b0, ovf0}, 32'h0);

    // Reset mid-frame discards the partial word.
    applyStimulus(8'hAA, 1'b1, 1'b0);
    applyStimulus(8'hBB, 1'b1, 1'b0);
    nrst = 1'b0;
    idleCycles(1);
    checkOutput("midRstValid", {31'b0, if0.dout_valid}, 32'h0);
    checkOutput("midRstBusy", {31'b0, busy0}, 32'h0);
    checkOutput("midRstFrameCnt", {16'b0, frameCnt0}, 32'h0);
    checkOutput("midRstDout", if0.dout, 32'h0);
    nrst = 1'b1;
    idleCycles(1);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b0);
    applyStimulus(8'h04, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("postRstWord", if0.dout, 32'h04030201);
    popWord();
    idleCycles(3);
    checkOutput("postRstOnly", {31'b0, if0.dout_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
